ram_port_sched: RTL and testbench

Round-robin scheduler sharing one single-port synchronous packet RAM among N requesters, such as Ethernet read, Ethernet write, CPU and DMA ports. Each requester issues a one-cycle strobe with address, direction and data. The scheduler queues each request in a per-port one-entry slot and grants one RAM access per cycle. Read data returns to the issuing port with a tagged valid pulse. It sits between the MAC/CPU bus adapters and the packet RAM macro.

---
 rtl/ram_port_sched.sv | 163 ++++++++++++++++
 tb/tb_ram_port_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_sched.sv
// +----------------------------------------------------------------------------+
// | Module      : ram_port_sched                                               |
// | Description : Round-robin scheduler sharing one single-port packet RAM     |
// |               among N_REQ requesters with one-entry slots and tagged read  |
// |               returns. Define RAM_PORT_SCHED_ETH_PRIO_EN to give ports 0/1 |
// |               strict priority over the remaining ports.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_port_sched #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ-1:0]          req_stb_i,
    input  logic [N_REQ-1:0]          req_we_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_busy_o,
    output logic [N_REQ-1:0]          req_ovr_o,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic [N_REQ-1:0]          rd_valid_o,
    output logic [ADDR_W-1:0]         ram_addr_o,
    output logic                      ram_cs_o,
    output logic                      ram_we_o,
    output logic [DATA_W-1:0]         ram_data_o,
    input  logic [DATA_W-1:0]         ram_data_i
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0][ADDR_W-1:0] r_addr;
    logic [N_REQ-1:0][DATA_W-1:0] r_data;
    logic [N_REQ-1:0]             r_we;
    logic [N_REQ-1:0]             r_pend;
    logic [c_IDX_W-1:0]           r_last;
    logic [c_IDX_W:0]             w_pick;
    logic                         w_gnt_vld;
    logic [c_IDX_W-1:0]           w_gnt_idx;
    logic [N_REQ-1:0]             w_gnt_oh;
    logic                         r_tag1_v;
    logic                         r_tag2_v;
    logic [c_IDX_W-1:0]           r_tag1;
    logic [c_IDX_W-1:0]           r_tag2;

    // Returns {valid, index} of the first set mask bit after 'last', wrapping.
    // Iterating from the far end lets the nearest candidate win without a break.
    function automatic logic [c_IDX_W:0] f_rr(input logic [N_REQ-1:0] mask,
                                              input logic [c_IDX_W-1:0] last);
        logic [c_IDX_W:0] res;
        int               idx;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (mask[idx]) res = {1'b1, c_IDX_W'(idx)};
        end
        return res;
    endfunction

`ifdef RAM_PORT_SCHED_ETH_PRIO_EN
    localparam logic [N_REQ-1:0] c_ETH_MASK = N_REQ'(3);

    logic [c_IDX_W-1:0] r_last_oth;
    logic [N_REQ-1:0]   w_eth_req;
    logic [N_REQ-1:0]   w_oth_req;

    always_comb begin
        w_eth_req = r_pend & c_ETH_MASK;
        w_oth_req = r_pend & ~c_ETH_MASK;
        if (|w_eth_req) w_pick = f_rr(w_eth_req, r_last);
        else            w_pick = f_rr(w_oth_req, r_last_oth);
    end

    // r_last tracks the Eth group, r_last_oth the remaining ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= c_IDX_W'(N_REQ - 1);
            r_last_oth <= c_IDX_W'(N_REQ - 1);
        end else if (w_gnt_vld) begin
            if (c_ETH_MASK[w_gnt_idx]) r_last     <= w_gnt_idx;
            else                       r_last_oth <= w_gnt_idx;
        end
    end
`else
    always_comb begin
        w_pick = f_rr(r_pend, r_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_last <= c_IDX_W'(N_REQ - 1);
        else if (w_gnt_vld) r_last <= w_gnt_idx;
    end
`endif

    assign w_gnt_vld  = w_pick[c_IDX_W];
    assign w_gnt_idx  = w_pick[c_IDX_W-1:0];
    assign w_gnt_oh   = w_gnt_vld ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign req_busy_o = r_pend;

    // A slot freed by this cycle's grant may accept a new strobe at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= '0;
            r_pend    <= '0;
            req_ovr_o <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (req_stb_i[k] && (!r_pend[k] || w_gnt_oh[k])) begin
                    r_pend[k] <= 1'b1;
                    r_addr[k] <= req_addr_i[k*ADDR_W +: ADDR_W];
                    r_data[k] <= req_data_i[k*DATA_W +: DATA_W];
                    r_we[k]   <= req_we_i[k];
                end else if (w_gnt_oh[k]) begin
                    r_pend[k] <= 1'b0;
                end
                if (req_stb_i[k] && r_pend[k] && !w_gnt_oh[k]) req_ovr_o[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_o <= '0;
            ram_cs_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            ram_data_o <= '0;
        end else begin
            ram_cs_o <= w_gnt_vld;
            ram_we_o <= w_gnt_vld & r_we[w_gnt_idx];
            if (w_gnt_vld) begin
                ram_addr_o <= r_addr[w_gnt_idx];
                ram_data_o <= r_data[w_gnt_idx];
            end
        end
    end

    // Stage 1 lines up with ram_cs_o, stage 2 with ram_data_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1_v   <= 1'b0;
            r_tag2_v   <= 1'b0;
            r_tag1     <= '0;
            r_tag2     <= '0;
            rd_valid_o <= '0;
            rd_data_o  <= '0;
        end else begin
            r_tag1_v   <= w_gnt_vld & ~r_we[w_gnt_idx];
            r_tag1     <= w_gnt_idx;
            r_tag2_v   <= r_tag1_v;
            r_tag2     <= r_tag1;
            rd_valid_o <= r_tag2_v ? (N_REQ'(1) << r_tag2) : '0;
            if (r_tag2_v) rd_data_o <= ram_data_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_sched.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_port_sched                                            |
// | Description : Directed bench for ram_port_sched with a behavioural RAM.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_port_sched;

    localparam int c_AW = 9;
    localparam int c_DW = 32;
    localparam int c_N  = 4;

    logic                 clk;
    logic                 rst_n;
    logic [c_N*c_AW-1:0]  r_req_addr;
    logic [c_N-1:0]       r_req_stb;
    logic [c_N-1:0]       r_req_we;
    logic [c_N*c_DW-1:0]  r_req_data;
    logic [c_N-1:0]       w_busy;
    logic [c_N-1:0]       w_ovr;
    logic [c_DW-1:0]      w_rd_data;
    logic [c_N-1:0]       w_rd_valid;
    logic [c_AW-1:0]      w_ram_addr;
    logic                 w_ram_cs;
    logic                 w_ram_we;
    logic [c_DW-1:0]      w_ram_wdata;
    logic [c_DW-1:0]      r_ram_rdata;
    logic [c_DW-1:0]      r_mem [0:(1<<c_AW)-1];

    int n_vec = 0;
    int n_err = 0;

    ram_port_sched #(.ADDR_W(c_AW), .DATA_W(c_DW), .N_REQ(c_N)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_addr_i (r_req_addr),
        .req_stb_i  (r_req_stb),
        .req_we_i   (r_req_we),
        .req_data_i (r_req_data),
        .req_busy_o (w_busy),
        .req_ovr_o  (w_ovr),
        .rd_data_o  (w_rd_data),
        .rd_valid_o (w_rd_valid),
        .ram_addr_o (w_ram_addr),
        .ram_cs_o   (w_ram_cs),
        .ram_we_o   (w_ram_we),
        .ram_data_o (w_ram_wdata),
        .ram_data_i (r_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_ram_cs) begin
            if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
            else          r_ram_rdata <= r_mem[w_ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic w, input logic [c_AW-1:0] a,
                           input logic [c_DW-1:0] d);
        r_req_stb[k]              = 1'b1;
        r_req_we[k]               = w;
        r_req_addr[k*c_AW +: c_AW] = a;
        r_req_data[k*c_DW +: c_DW] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {w_busy, w_ovr, w_rd_valid, w_ram_cs, w_ram_we}, 64'h0);
        chk({tag, "_addr"}, w_ram_addr, 64'h0);
        chk({tag, "_wdata"}, w_ram_wdata, 64'h0);
        chk({tag, "_rdata"}, w_rd_data, 64'h0);
    endtask

    logic [c_N-1:0]  r_rv_acc;
    logic            r_seen_bad;
    logic [c_AW-1:0] r_exp_a [0:3];
    logic [c_DW-1:0] r_exp_d [0:3];

    initial begin
        for (int i = 0; i < (1 << c_AW); i++) r_mem[i] = 32'h0;
        r_mem[9'h15A] = 32'hDEADBEEF;
        for (int k = 0; k < c_N; k++) r_mem[9'h100 + k] = 32'hA0 + k;
        r_ram_rdata = '0;
        r_req_addr  = '0;
        r_req_stb   = '0;
        r_req_we    = '0;
        r_req_data  = '0;
        rst_n       = 1'b0;

        // reset state
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // single read, port 2
        set_req(2, 1'b0, 9'h15A, 32'h0);
        tick(); r_req_stb = '0;
        chk("rd_busy_e0", w_busy, 4'b0100);
        chk("rd_cs_e0", w_ram_cs, 1'b0);
        tick();
        chk("rd_cs_e1", {w_ram_cs, w_ram_we}, 2'b10);
        chk("rd_addr_e1", w_ram_addr, 9'h15A);
        chk("rd_busy_e1", w_busy, 4'b0000);
        tick();
        chk("rd_cs_e2", w_ram_cs, 1'b0);
        chk("rd_rv_e2", w_rd_valid, 4'b0000);
        tick();
        chk("rd_rv_e3", w_rd_valid, 4'b0100);
        chk("rd_data_e3", w_rd_data, 32'hDEADBEEF);
        tick();
        chk("rd_rv_e4", w_rd_valid, 4'b0000);
        chk("rd_hold_e4", w_rd_data, 32'hDEADBEEF);

        // single write, port 1
        set_req(1, 1'b1, 9'h0C3, 32'h12345678);
        tick(); r_req_stb = '0;
        tick();
        chk("wr_cs", {w_ram_cs, w_ram_we}, 2'b11);
        chk("wr_addr", w_ram_addr, 9'h0C3);
        chk("wr_data", w_ram_wdata, 32'h12345678);
        r_rv_acc = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            r_rv_acc |= w_rd_valid;
            chk("wr_cs_once", w_ram_cs, 1'b0);
        end
        chk("wr_no_return", r_rv_acc, 4'b0000);

        // reset one cycle after a read's chip select
        set_req(3, 1'b0, 9'h15A, 32'h0);
        tick(); r_req_stb = '0;
        tick();
        chk("rst_cs_e1", w_ram_cs, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick(); tick();
        rst_n = 1'b1;
        r_rv_acc = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            r_rv_acc |= w_rd_valid;
        end
        chk("rst_no_return", r_rv_acc, 4'b0000);

        // simultaneous reads on all ports just after reset
        for (int k = 0; k < c_N; k++) set_req(k, 1'b0, 9'h100 + k, 32'h0);
        tick(); r_req_stb = '0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 4) begin
                chk("burst_cs", w_ram_cs, 1'b1);
                chk("burst_addr", w_ram_addr, 9'h100 + i - 1);
            end
            if (i >= 3) begin
                chk("burst_rv", w_rd_valid, 4'b0001 << (i - 3));
                chk("burst_rdata", w_rd_data, 32'hA0 + i - 3);
            end
        end

        // second all-port burst, writes
        for (int k = 0; k < c_N; k++) set_req(k, 1'b1, 9'h110 + k, 32'hB0 + k);
        tick(); r_req_stb = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst2_cs", {w_ram_cs, w_ram_we}, 2'b11);
            chk("burst2_addr", w_ram_addr, 9'h110 + i);
            chk("burst2_data", w_ram_wdata, 32'hB0 + i);
        end
        tick();
        chk("burst2_idle", w_ram_cs, 1'b0);

        // strobe in the grant cycle refills the slot with no overrun
        set_req(2, 1'b0, 9'h15A, 32'h0);
        tick(); r_req_stb = '0;
        set_req(2, 1'b0, 9'h0C3, 32'h0);
        tick(); r_req_stb = '0;
        chk("gc_addr_e1", w_ram_addr, 9'h15A);
        chk("gc_busy_e1", w_busy, 4'b0100);
        chk("gc_ovr_e1", w_ovr, 4'b0000);
        tick();
        chk("gc_cs_e2", w_ram_cs, 1'b1);
        chk("gc_addr_e2", w_ram_addr, 9'h0C3);
        chk("gc_busy_e2", w_busy, 4'b0000);
        tick();
        chk("gc_rv_e3", w_rd_valid, 4'b0100);
        chk("gc_rd_e3", w_rd_data, 32'hDEADBEEF);
        tick();
        chk("gc_rv_e4", w_rd_valid, 4'b0100);
        chk("gc_rd_e4", w_rd_data, 32'h12345678);
        tick();
        chk("gc_rv_e5", w_rd_valid, 4'b0000);

        // overrun: port 0 restrobes while queued behind the others
        set_req(0, 1'b1, 9'h050, 32'h5);
        tick(); r_req_stb = '0;
        tick(); tick();
        set_req(0, 1'b1, 9'h1AA, 32'h11110000);
        for (int k = 1; k < c_N; k++) set_req(k, 1'b1, 9'h1B0 + k, 32'h33330000 + k);
        tick(); r_req_stb = '0;
        chk("ovr_pre", w_ovr, 4'b0000);
        set_req(0, 1'b1, 9'h1EE, 32'h22220000);
`ifdef RAM_PORT_SCHED_ETH_PRIO_EN
        r_exp_a = '{9'h1B1, 9'h1AA, 9'h1B2, 9'h1B3};
        r_exp_d = '{32'h33330001, 32'h11110000, 32'h33330002, 32'h33330003};
`else
        r_exp_a = '{9'h1B1, 9'h1B2, 9'h1B3, 9'h1AA};
        r_exp_d = '{32'h33330001, 32'h33330002, 32'h33330003, 32'h11110000};
`endif
        r_seen_bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(); r_req_stb = '0;
            if (w_ram_cs && w_ram_addr == 9'h1EE) r_seen_bad = 1'b1;
            if (i == 0) begin
                chk("ovr_set", w_ovr, 4'b0001);
                chk("ovr_busy", w_busy, 4'b1101);
            end
            if (i < 4) begin
                chk("ovr_cs", {w_ram_cs, w_ram_we}, 2'b11);
                chk("ovr_addr", w_ram_addr, r_exp_a[i]);
                chk("ovr_data", w_ram_wdata, r_exp_d[i]);
            end
        end
        chk("ovr_dropped", r_seen_bad, 1'b0);
        chk("ovr_sticky", w_ovr, 4'b0001);

`ifdef RAM_PORT_SCHED_ETH_PRIO_EN
        // Eth port restrobed every cycle starves port 3 until it goes quiet
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_req(3, 1'b0, 9'h003, 32'h0);
        set_req(0, 1'b0, 9'h000, 32'h0);
        tick(); r_req_stb[3] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) r_req_stb = '0;
            chk("prio_cs", w_ram_cs, 1'b1);
            chk("prio_addr", w_ram_addr, (i <= 4) ? 9'h000 : 9'h003);
        end
        chk("prio_ovr", w_ovr, 4'b0000);
        chk("prio_busy", w_busy, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
